// File: rtl/mem_arbiter.sv
// Round-robin arbiter and three-phase access sequencer that shares one word memory
// between the instruction-fetch port and the load/store port.
module mem_arbiter #(
   parameter int Size = 256
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_ack,
   output logic        if_err,
   output logic [31:0] if_rdata,
   input  logic        dm_req,
   input  logic        dm_we,
   input  logic [31:0] dm_addr,
   input  logic [31:0] dm_wdata,
   output logic        dm_ack,
   output logic        dm_err,
   output logic [31:0] dm_rdata,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   output logic        busy
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ACCESS = 2'd1;
   localparam logic [1:0] RESP   = 2'd2;

   localparam logic OWN_IF = 1'b0;
   localparam logic OWN_DM = 1'b1;

   localparam logic [29:0] WORD_LIMIT = 30'(Size);

   logic [1:0]  state;
   logic        owner;
   logic        last;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic        we_q;
   logic        err_q;

   logic        grant_if;
   logic        grant_dm;
   logic [31:0] win_addr;
   logic        win_err;

   // On a tie the port that did not win last time is served.
   always_comb begin
      grant_if = 1'b0;
      grant_dm = 1'b0;
      if (state == IDLE) begin
         grant_if = if_req && (!dm_req || (last == OWN_DM));
         grant_dm = dm_req && (!if_req || (last == OWN_IF));
      end
   end

   always_comb begin
      win_addr = grant_dm ? dm_addr : if_addr;
      win_err  = (win_addr[1:0] != 2'b00) || (win_addr[31:2] >= WORD_LIMIT);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         owner    <= OWN_IF;
         last     <= OWN_DM;
         addr_q   <= 32'h0;
         wdata_q  <= 32'h0;
         we_q     <= 1'b0;
         err_q    <= 1'b0;
         if_ack   <= 1'b0;
         if_err   <= 1'b0;
         if_rdata <= 32'h0;
         dm_ack   <= 1'b0;
         dm_err   <= 1'b0;
         dm_rdata <= 32'h0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_if || grant_dm) begin
                  state   <= ACCESS;
                  owner   <= grant_dm ? OWN_DM : OWN_IF;
                  last    <= grant_dm ? OWN_DM : OWN_IF;
                  addr_q  <= win_addr;
                  we_q    <= grant_dm && dm_we;
                  wdata_q <= grant_dm ? dm_wdata : 32'h0;
                  err_q   <= win_err;
               end
            end
            ACCESS: begin
               state <= RESP;
               if (owner == OWN_DM) begin
                  dm_ack <= 1'b1;
                  dm_err <= err_q;
                  if (!err_q && !we_q) begin
                     dm_rdata <= mem_rdata;
                  end
               end else begin
                  if_ack <= 1'b1;
                  if_err <= err_q;
                  if (!err_q && !we_q) begin
                     if_rdata <= mem_rdata;
                  end
               end
            end
            RESP: begin
               state  <= IDLE;
               if_ack <= 1'b0;
               if_err <= 1'b0;
               dm_ack <= 1'b0;
               dm_err <= 1'b0;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Write enable is combinational so a reset during ACCESS kills the write at once.
   assign mem_we    = (state == ACCESS) && we_q && !err_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: behavioural word memory, hand-computed expectations,
// one line per transaction and a single summary line.
module tb_mem_arbiter;

   logic        clk;
   logic        reset;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_ack;
   logic        if_err;
   logic [31:0] if_rdata;
   logic        dm_req;
   logic        dm_we;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic        dm_ack;
   logic        dm_err;
   logic [31:0] dm_rdata;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        busy;

   int checks = 0;
   int errors = 0;
   int we_pulses = 0;

   logic [31:0] mem [0:255];

   mem_arbiter #(.Size(256)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_err(if_err), .if_rdata(if_rdata),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_ack(dm_ack), .dm_err(dm_err), .dm_rdata(dm_rdata),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign mem_rdata = mem[mem_addr[9:2]];

   always @(posedge clk) begin
      if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
   end

   always @(negedge clk) begin
      if (mem_we) we_pulses = we_pulses + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   // One request on one port; checks latency, single-cycle ack, and returns err.
   task automatic xact(input bit is_dm, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input string tag, output logic err);
      int  lat;
      bit  got;
      @(posedge clk); #1;
      we_pulses = 0;
      if (is_dm) begin
         dm_req = 1'b1; dm_we = we; dm_addr = addr; dm_wdata = wdata;
      end else begin
         if_req = 1'b1; if_addr = addr;
      end
      lat = 0; got = 0; err = 1'b0;
      while (!got && lat < 12) begin
         @(negedge clk);
         lat++;
         if (is_dm ? dm_ack : if_ack) begin
            got = 1;
            err = is_dm ? dm_err : if_err;
         end
      end
      @(posedge clk); #1;
      if_req = 1'b0; dm_req = 1'b0;
      @(negedge clk);
      check({tag, "_lat"}, 32'(lat), 32'd3);
      check({tag, "_ackdone"}, {29'b0, if_ack, dm_ack, busy}, 32'd0);
      $display("xact %s port=%s we=%0d addr=%h lat=%0d err=%0d writes=%0d",
               tag, is_dm ? "DM" : "IF", we, addr, lat, err, we_pulses);
   endtask

   initial begin
      logic e;
      bit   if_drop, dm_drop;
      int   n;
      int   ack_port [8];
      int   ack_cyc  [8];

      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      mem[0]   = 32'h0BAD_F00D;
      mem[2]   = 32'h0000_0077;
      mem[3]   = 32'h2008_0005;
      mem[255] = 32'hCAFE_0001;

      reset = 1'b0;
      if_req = 1'b1; if_addr = 32'h0;
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0; dm_wdata = 32'h0;

      repeat (3) @(negedge clk);
      check("rst_acks", {28'b0, if_ack, if_err, dm_ack, dm_err}, 32'd0);
      check("rst_busy_we", {30'b0, busy, mem_we}, 32'd0);
      check("rst_if_rdata", if_rdata, 32'h0);
      check("rst_dm_rdata", dm_rdata, 32'h0);
      reset = 1'b1;

      // Both ports hammer the arbiter, each backing off one cycle after its ack.
      if_drop = 0; dm_drop = 0; n = 0;
      for (int c = 1; c <= 13; c++) begin
         @(posedge clk); #1;
         if_req = !if_drop;
         dm_req = !dm_drop;
         @(negedge clk);
         if_drop = if_ack;
         dm_drop = dm_ack;
         if (if_ack && n < 8) begin ack_port[n] = 0; ack_cyc[n] = c; n++; end
         if (dm_ack && n < 8) begin ack_port[n] = 1; ack_cyc[n] = c; n++; end
      end
      check("cont_count", {31'b0, n >= 4}, 32'd1);
      for (int i = 0; i < 4 && i < n; i++) begin
         check($sformatf("cont_order%0d", i), 32'(ack_port[i]), 32'(i % 2));
         if (i > 0) check($sformatf("cont_gap%0d", i), 32'(ack_cyc[i] - ack_cyc[i-1]), 32'd3);
         $display("xact contention ack=%0d port=%s cycle=%0d", i, ack_port[i] == 0 ? "IF" : "DM", ack_cyc[i]);
      end
      if_req = 1'b0; dm_req = 1'b0;
      for (int i = 0; i < 10 && busy; i++) @(negedge clk);
      @(negedge clk);
      check("cont_idle", {31'b0, busy}, 32'd0);
      check("cont_if_rdata", if_rdata, 32'h0BAD_F00D);
      check("cont_dm_rdata", dm_rdata, 32'h0BAD_F00D);

      xact(1'b0, 1'b0, 32'h0000_000C, 32'h0, "fetch_w3", e);
      check("fetch_w3_err", {31'b0, e}, 32'd0);
      check("fetch_w3_rdata", if_rdata, 32'h2008_0005);
      check("fetch_w3_nowrite", 32'(we_pulses), 32'd0);

      xact(1'b1, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF, "store_40", e);
      check("store_40_err", {31'b0, e}, 32'd0);
      check("store_40_we1", 32'(we_pulses), 32'd1);
      check("store_40_mem", mem[16], 32'hDEAD_BEEF);
      check("store_40_rdata_hold", dm_rdata, 32'h0BAD_F00D);

      xact(1'b1, 1'b0, 32'h0000_0040, 32'h0, "load_40", e);
      check("load_40_err", {31'b0, e}, 32'd0);
      check("load_40_rdata", dm_rdata, 32'hDEAD_BEEF);

      xact(1'b1, 1'b1, 32'h0000_0041, 32'h5555_5555, "store_41", e);
      check("store_41_err", {31'b0, e}, 32'd1);
      check("store_41_nowrite", 32'(we_pulses), 32'd0);
      check("store_41_mem", mem[16], 32'hDEAD_BEEF);
      check("store_41_rdata", dm_rdata, 32'hDEAD_BEEF);

      xact(1'b0, 1'b0, 32'h0000_0400, 32'h0, "fetch_400", e);
      check("fetch_400_err", {31'b0, e}, 32'd1);
      check("fetch_400_rdata", if_rdata, 32'h2008_0005);

      xact(1'b0, 1'b0, 32'h0000_03FC, 32'h0, "fetch_3fc", e);
      check("fetch_3fc_err", {31'b0, e}, 32'd0);
      check("fetch_3fc_rdata", if_rdata, 32'hCAFE_0001);

      // Reset lands in the middle of the ACCESS cycle of a store.
      @(posedge clk); #1;
      dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h0000_0008; dm_wdata = 32'h0000_1234;
      @(posedge clk); #1;
      check("rstacc_pre", {30'b0, busy, mem_we}, 32'd3);
      reset = 1'b0;
      #1;
      check("rstacc_now", {29'b0, busy, mem_we, dm_ack}, 32'd0);
      dm_req = 1'b0;
      repeat (2) begin
         @(negedge clk);
         check("rstacc_noack", {30'b0, dm_ack, busy}, 32'd0);
      end
      check("rstacc_mem", mem[2], 32'h0000_0077);
      check("rstacc_rdata", dm_rdata, 32'h0);
      reset = 1'b1;
      $display("xact reset_mid_access addr=00000008 word2=%h", mem[2]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and access sequencer for the single-port unified word memory of the multicycle core. It shares the memory between the instruction-fetch requester and the load/store requester. Each access is a three-state transaction: IDLE, ACCESS and RESP. The block also rejects misaligned and out-of-range addresses before they reach the array. It sits between the control unit's fetch/data ports and the memory's `we`/`data_addr`/`write_data`/`read_data` pins.

## Interface
- `Size`, 256, memory depth in 32-bit words; valid word index is 0..Size-1
- `clk` input 1 — single clock, all state updates on rising edge
- `reset` input 1 — asynchronous, active-low (0 = reset asserted)
- `if_req` input 1 — fetch request; held high until `if_ack`
- `if_addr` input 32 — fetch byte address
- `if_ack` output 1 — one-cycle completion pulse for fetch
- `if_err` output 1 — valid with `if_ack`; access was rejected
- `if_rdata` output 32 — fetched word; valid with `if_ack`, held until next fetch ack
- `dm_req` input 1 — data request; held high until `dm_ack`
- `dm_we` input 1 — 1 = store, 0 = load
- `dm_addr` input 32 — data byte address
- `dm_wdata` input 32 — store data
- `dm_ack` output 1 — one-cycle completion pulse for data
- `dm_err` output 1 — valid with `dm_ack`
- `dm_rdata` output 32 — loaded word; valid with `dm_ack`, holds its value on store and on error
- `mem_we` output 1 — memory write enable
- `mem_addr` output 32 — memory byte address
- `mem_wdata` output 32 — memory write data
- `mem_rdata` input 32 — combinational memory read data
- `busy` output 1 — high whenever state != IDLE

## Operation
- **Registered state:**
  - `state` (IDLE/ACCESS/RESP)
  - `owner` (IF/DM)
  - `last` (last granted port)
  - latched `addr_q`, `we_q`, `wdata_q`, `err_q`
  - `if_rdata`, `dm_rdata`, `if_ack`, `dm_ack`, `if_err`, `dm_err`
- **Reset values:**
  - state = IDLE, `last` = DM, so the first tie goes to IF
  - all acks and errs = 0
  - `if_rdata` = `dm_rdata` = 0
  - `addr_q` = `wdata_q` = 0, `we_q` = `err_q` = 0
- **IDLE:**
  - If no request is pending, stay in IDLE.
  - If only one request is pending, grant it.
  - If both are pending, grant the port that is not `last` (round-robin).
  - On the grant edge, latch the winner's address, write flag (always 0 for IF) and write data. Set `owner` and `last`, then go to ACCESS.
  - Set `err_q` = (`addr[1:0]` != 0) | (`addr[31:2]` >= Size).
- **ACCESS:**
  - `mem_we` = `we_q` & ~`err_q`.
  - At the closing edge, if `err_q` = 0 and `we_q` = 0, capture `mem_rdata` into the owner's rdata register.
  - Set the owner's ack = 1 and err = `err_q`, then go to RESP.
- **RESP:**
  - The owner's ack is high for exactly this cycle.
  - At the closing edge, clear the ack and err and return to IDLE.
  - The arbiter does not sample requests in RESP.
- **Memory-side outputs:**
  - `mem_addr` = `addr_q` and `mem_wdata` = `wdata_q` in all states.
  - `mem_we` is 0 in every state except ACCESS.
- **Erroneous access:** the memory is never written, rdata is not updated, and ack still completes with err = 1.
- **Requester rules:**
  - A requester must drop `req` in the cycle after it sees ack.
  - A requester must keep its address and data stable from `req` rise until ack. The arbiter latches them anyway, so later changes are ignored.

## Timing
- Request visible during IDLE cycle k → grant edge ends k → ACCESS in k+1 (write commits at its closing edge) → ack high in k+2 → IDLE in k+3.
- Minimum spacing is 3 cycles per access; peak throughput is 1 access per 3 cycles.
- Under continuous requests from both ports, grants strictly alternate. Neither port waits more than one transaction (3 cycles) beyond its own.
- A request arriving during ACCESS or RESP is served from the next IDLE.
- **Reset asserted mid-ACCESS:** state goes to IDLE immediately, `mem_we` drops combinationally, no write is performed, and no ack is issued.
- **Reset asserted mid-RESP:** the ack is cleared immediately.

## Test plan
- **Reset:** hold `reset` = 0 with `if_req` = `dm_req` = 1 → all acks and errs 0, `busy` = 0, `mem_we` = 0, rdata = 0. After release, the first grant goes to IF.
- **Single fetch:** memory word 3 = 0x2008_0005; `if_req` with `if_addr` = 0xC → `if_ack` exactly 2 cycles after the grant edge, `if_rdata` = 0x2008_0005, `if_err` = 0, `mem_we` never 1.
- **Store then load:**
  - `dm_we` = 1, `dm_addr` = 0x40, `dm_wdata` = 0xDEAD_BEEF → `mem_we` = 1 for exactly one cycle, `dm_ack` pulse, `dm_rdata` unchanged.
  - Then a load from 0x40 → `dm_rdata` = 0xDEAD_BEEF.
- **Contention:** hold `if_req` and `dm_req` high from reset, each requester dropping `req` for one cycle after its ack → order IF, DM, IF, DM; acks 3 cycles apart.
- **Errors:**
  - Store to 0x41 → `dm_err` = 1, no write to word 0x10.
  - Fetch from 0x400 with Size = 256 → `if_err` = 1, `if_rdata` unchanged.
- **Reset mid-ACCESS:** assert `reset` = 0 during the ACCESS cycle of a store of 0x1234 to 0x8 → word 2 keeps its old value, no `dm_ack`, `busy` = 0.
